// File: rtl/tri_pkg.sv
// tri_pkg: shared definitions for the triangle receiver.
//   - bit offsets and widths of the 256-bit triangle record
//   - tri_rec_t: the compacted record actually stored in the FIFO
//     (reserved bits [79:1] are dropped)
//   - state_t: frame FSM encoding
package tri_pkg;

   localparam int REC_W    = 256;
   localparam int COORD_W  = 16;
   localparam int DEPTH_W  = 16;
   localparam int COLOR_W  = 32;

   localparam int V0X_LSB  = 240;
   localparam int V0Y_LSB  = 224;
   localparam int V1X_LSB  = 208;
   localparam int V1Y_LSB  = 192;
   localparam int V2X_LSB  = 176;
   localparam int V2Y_LSB  = 160;
   localparam int COLOR_LSB = 128;
   localparam int Z0_LSB   = 112;
   localparam int Z1_LSB   = 96;
   localparam int Z2_LSB   = 80;
   localparam int RSV_MSB  = 79;
   localparam int RSV_LSB  = 1;
   localparam int LAST_BIT = 0;

   typedef struct packed {
      logic signed [COORD_W-1:0] v0x;
      logic signed [COORD_W-1:0] v0y;
      logic signed [COORD_W-1:0] v1x;
      logic signed [COORD_W-1:0] v1y;
      logic signed [COORD_W-1:0] v2x;
      logic signed [COORD_W-1:0] v2y;
      logic [COLOR_W-1:0]        color;
      logic [DEPTH_W-1:0]        z0;
      logic [DEPTH_W-1:0]        z1;
      logic [DEPTH_W-1:0]        z2;
      logic                      last;
   } tri_rec_t;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/tri_fifo.sv
// tri_fifo: DEPTH-entry register FIFO.
//   clk, rst     clock, asynchronous active-low reset
//   push, pop    write / read strobes; the caller guarantees push only when
//                there is room (or a pop in the same cycle) and pop only
//                when not empty
//   wr_data      record to write
//   rd_data      head record (combinational from storage)
//   count        occupancy, 0..DEPTH
// Pointers wrap modulo DEPTH; full/empty are judged from count only.
module tri_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 256,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CW-1:0]    count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/triangle_receiver.sv
// triangle_receiver: input stage of the processing unit.
//   clk, rst           clock, asynchronous active-low reset
//   i_triangle_valid   one-cycle pulse, i_triangle_data holds a record
//   i_triangle_data    256-bit triangle record
//   o_proc_ready       registered permission for upstream to send one record
//   o_tri_valid        head record available
//   i_tri_ready        downstream accepts the head record
//   o_v*/o_z*/o_color  unpacked head fields
//   o_tri_last         head record closes the frame
//   o_frame_done       one-cycle pulse after the last record is popped
//   o_overflow         sticky protocol-error flag
//   o_count            FIFO occupancy
module triangle_receiver
   import tri_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_triangle_valid,
   input  logic [REC_W-1:0]          i_triangle_data,
   output logic                      o_proc_ready,
   output logic                      o_tri_valid,
   input  logic                      i_tri_ready,
   output logic signed [COORD_W-1:0] o_v0x,
   output logic signed [COORD_W-1:0] o_v0y,
   output logic signed [COORD_W-1:0] o_v1x,
   output logic signed [COORD_W-1:0] o_v1y,
   output logic signed [COORD_W-1:0] o_v2x,
   output logic signed [COORD_W-1:0] o_v2y,
   output logic [DEPTH_W-1:0]        o_z0,
   output logic [DEPTH_W-1:0]        o_z1,
   output logic [DEPTH_W-1:0]        o_z2,
   output logic [COLOR_W-1:0]        o_color,
   output logic                      o_tri_last,
   output logic                      o_frame_done,
   output logic                      o_overflow,
   output logic [CW-1:0]             o_count
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   tri_rec_t      wr_rec;
   tri_rec_t      head;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          pop;
   logic          accept;
   logic          overflow_set;
   state_t        state;
   state_t        state_next;
   logic          ready_next;
   logic          done_next;

   // Reserved record bits are deliberately discarded before storage.
   logic unused_reserved;
   assign unused_reserved = ^i_triangle_data[RSV_MSB:RSV_LSB];

   assign wr_rec = '{
      v0x:   i_triangle_data[V0X_LSB   +: COORD_W],
      v0y:   i_triangle_data[V0Y_LSB   +: COORD_W],
      v1x:   i_triangle_data[V1X_LSB   +: COORD_W],
      v1y:   i_triangle_data[V1Y_LSB   +: COORD_W],
      v2x:   i_triangle_data[V2X_LSB   +: COORD_W],
      v2y:   i_triangle_data[V2Y_LSB   +: COORD_W],
      color: i_triangle_data[COLOR_LSB +: COLOR_W],
      z0:    i_triangle_data[Z0_LSB    +: DEPTH_W],
      z1:    i_triangle_data[Z1_LSB    +: DEPTH_W],
      z2:    i_triangle_data[Z2_LSB    +: DEPTH_W],
      last:  i_triangle_data[LAST_BIT]
   };

   // A full FIFO still accepts a record when the head leaves in the same cycle.
   assign pop          = o_tri_valid & i_tri_ready;
   assign accept       = i_triangle_valid & ((count < FULL) | pop);
   assign count_next   = count + CW'(accept) - CW'(pop);
   assign overflow_set = i_triangle_valid & (~accept | (state == DRAIN));

   tri_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(tri_rec_t)),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (accept),
      .pop     (pop),
      .wr_data (wr_rec),
      .rd_data (head),
      .count   (count)
   );

   // Frame FSM next state. Upstream is throttled from the cycle after the
   // last record is accepted until that same record has been popped.
   always_comb begin
      state_next = state;
      ready_next = (count_next < FULL);
      done_next  = 1'b0;
      case (state)
         RUN: begin
            if (accept && wr_rec.last) begin
               state_next = DRAIN;
               ready_next = 1'b0;
            end
         end
         DRAIN: begin
            ready_next = 1'b0;
            if (pop && head.last) begin
               state_next = RUN;
               done_next  = 1'b1;
               ready_next = (count_next < FULL);
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= RUN;
         o_proc_ready <= 1'b0;
         o_frame_done <= 1'b0;
         o_overflow   <= 1'b0;
      end else begin
         state        <= state_next;
         o_proc_ready <= ready_next;
         o_frame_done <= done_next;
         o_overflow   <= o_overflow | overflow_set;
      end
   end

   assign o_count     = count;
   assign o_tri_valid = (count != '0);
   assign o_v0x       = head.v0x;
   assign o_v0y       = head.v0y;
   assign o_v1x       = head.v1x;
   assign o_v1y       = head.v1y;
   assign o_v2x       = head.v2x;
   assign o_v2y       = head.v2y;
   assign o_z0        = head.z0;
   assign o_z1        = head.z1;
   assign o_z2        = head.z2;
   assign o_color     = head.color;
   assign o_tri_last  = head.last;

endmodule
